// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-level FSM states and default frame geometry.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

endpackage

// File: rtl/uart_receive_sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: oversampled start/data/stop sampling with a one-cycle
// DATA_READY strobe and a FRAME_ERR strobe for a low stop bit.
module uart_receive
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UART_CLK_X16,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DATA_READY,
  output logic                 FRAME_ERR,
  output logic                 IDLE,
  output state_t               STATE_DBG
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  state_t                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   ready_q, ready_d;
  logic                   ferr_q, ferr_d;
  logic                   armed_q, armed_d;
  logic                   rxd_prev_q;
  logic                   rxd_s;
  logic                   start_seen;

  sync_2ff #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (RXD),
    .q_o    (rxd_s)
  );

  // A start is a falling edge on the synchronized line, ignored while locked out.
  assign start_seen = rxd_prev_q && !rxd_s && armed_q;

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q | rxd_s;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (start_seen) state_d = S_START;
      end
      S_START: begin
        if (UART_CLK_X16) begin
          if (tcnt_q == T_HALF) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = rxd_s ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (UART_CLK_X16) begin
          if (tcnt_q == T_LAST) begin
            shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
            tcnt_d  = '0;
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (UART_CLK_X16) begin
          if (tcnt_q == T_LAST) begin
            if (rxd_s) begin
              data_d  = shift_q;
              ready_d = 1'b1;
            end else begin
              // Lock out restarts until the line has been seen high again.
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
            tcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
      armed_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
      armed_q    <= armed_d;
      rxd_prev_q <= rxd_s;
    end
  end

  assign DATA       = data_q;
  assign DATA_READY = ready_q;
  assign FRAME_ERR  = ferr_q;
  assign IDLE       = (state_q == S_IDLE) && !start_seen;
  assign STATE_DBG  = state_q;

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- 8N1 UART receiver; the receive-side counterpart of uart_send, sharing its CLK domain and tick-enable style.
- Deserialises RXD using an oversampling tick, UART_CLK_X16, which is a single-CLK-cycle enable at OVERSAMPLE × baud.
- Presents each received byte on DATA with a one-cycle DATA_READY strobe. Reports bad stop bits on FRAME_ERR.
- Feeds the command/config path from the host link.

Parameters:
- OVERSAMPLE, 16, number of UART_CLK_X16 ticks per bit. Must be even and ≥ 4.
- DATA_BITS, 8, payload bits per frame, sent LSB first.

Ports:
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  reset; synchronous, active-low (RST=0 resets on the next CLK edge).
- UART_CLK_X16  in  1  oversample enable, synchronous to CLK, one CLK cycle high per tick.
- RXD  in  1  serial input; asynchronous; idles high.
- DATA  out  DATA_BITS  last received byte; held until the next frame completes.
- DATA_READY  out  1  one-CLK pulse; DATA is valid in the same cycle.
- FRAME_ERR  out  1  one-CLK pulse; stop bit was sampled low.
- IDLE  out  1  high when in S_IDLE and no frame is in progress.

Behaviour:
- Reset values: DATA=0, DATA_READY=0, FRAME_ERR=0, IDLE=1. State goes to S_IDLE, counters clear, and the synchronizer flops are set to 1.
- Reset mid-frame aborts the frame with no strobe.
- RXD passes through a 2-flop synchronizer (rxd_s). A falling edge is detected from rxd_s and its previous value. All state decisions use rxd_s.
- Tick counter tcnt ($clog2(OVERSAMPLE) bits) advances only on cycles where UART_CLK_X16=1. A bit counter counts 0..DATA_BITS-1.
- S_IDLE:
  - On an rxd_s falling edge (gated by the armed flag), clear tcnt and go to S_START. IDLE drops in that same cycle.
- S_START:
  - When tcnt reaches OVERSAMPLE/2-1 on a tick, sample rxd_s.
  - If low: clear tcnt and the bit counter, then go to S_DATA.
  - If high (glitch or false start): return to S_IDLE with no strobe.
- S_DATA:
  - When tcnt reaches OVERSAMPLE-1 on a tick, shift rxd_s into the MSB of the shift register (LSB-first reception) and clear tcnt.
  - After the DATA_BITS-th sample, go to S_STOP.
- S_STOP:
  - When tcnt reaches OVERSAMPLE-1 on a tick, sample rxd_s.
  - If high: DATA ← shift register and DATA_READY=1 for exactly one CLK cycle (the cycle after the sampling tick).
  - If low: FRAME_ERR=1 for one cycle. DATA is unchanged and DATA_READY stays 0.
  - Either way, go to S_IDLE at the stop-bit midpoint. This allows back-to-back frames with zero idle time.
- Break/framing-error lockout: after FRAME_ERR, the armed flag is cleared. A new start is accepted only after rxd_s has been seen high for at least 1 CLK cycle, which prevents a held-low line from retriggering.
- Latency: stop-bit midpoint tick → DATA_READY is 1 CLK cycle. RXD pin → rxd_s is 2 CLK cycles.
- Boundary cases:
  - A falling edge in the same cycle that S_STOP exits is not seen; the next edge is required.
  - A tick and an edge in the same cycle: the edge takes priority and tcnt starts at 0.
  - DATA_READY and FRAME_ERR are never asserted together.
  - There is no back-pressure. The consumer must take DATA within one frame time, otherwise it is overwritten silently.

Decomposition:
- uart_pkg holds:
  - state enum {S_IDLE, S_START, S_DATA, S_STOP}
  - DATA_BITS default
  - OVERSAMPLE default
  This package is shared with uart_send.
- Sub-module sync_2ff: generic 2-flop synchronizer with a parameterised reset value. It is used for RXD and is reusable for other async inputs.

Test Plan (CLK 10 ns; tick every 5 CLK; bit = 16 ticks = 800 ns):
- Frame 0xAA with correct stop bit → DATA=0xAA; one DATA_READY pulse about 9.5 bit times after the start edge; FRAME_ERR=0; IDLE returns to 1.
- 0xAA then 0x4C back-to-back with no idle bit → two DATA_READY pulses, DATA=0xAA then 0x4C, no FRAME_ERR.
- RXD low for 4 ticks then high → no strobe, state returns to S_IDLE, IDLE=1, DATA unchanged.
- 0x55 with stop bit 0, then RXD held low for 3 bit times, then high, then a valid 0x3C → exactly one FRAME_ERR pulse, no DATA_READY for the bad frame, no spurious start during the low hold, then DATA=0x3C with a DATA_READY pulse.
- RST=0 for 1 cycle during bit 4 of 0xFF, then a valid 0x12 → no strobe from the aborted frame; DATA reads 0x00 until the 0x12 frame completes, then 0x12 with a DATA_READY pulse.
- Loopback: uart_send TXD → RXD, with uart_send's bit tick equal to every 16th UART_CLK_X16, sending 0x00, 0xFF, 0xA5 → received bytes match in order, 3 DATA_READY pulses, 0 FRAME_ERR.
